// File: rtl/fetcher.sv
// Instruction fetch unit: requests instruction words, predicts next PC (BHT / JAL), emits packets.
// Latency: request registered one cycle after IDLE; packet registered on the edge sampling finish.
// Backpressure: any downstream full blocks new requests in IDLE only; rdy low freezes all state.
module fetcher #(
  parameter logic [31:0] RESET_PC       = 32'h0,
  parameter int          BHT_INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        enable_sign_to_mem,
  output logic [31:0] addr_to_mem,
  input  logic        finish_sign_from_mem,
  input  logic [31:0] inst_from_mem,
  input  logic        full_sign_from_rob,
  input  logic        full_sign_from_rs,
  input  logic        full_sign_from_ls,
  input  logic        rollback_sign_from_rob,
  input  logic [31:0] target_pc_from_rob,
  input  logic        update_sign_from_rob,
  input  logic [31:0] update_pc_from_rob,
  input  logic        jump_taken_from_rob,
  output logic        finish_flag_to_cmd,
  output logic [31:0] inst_to_cmd,
  output logic [31:0] pc_to_cmd,
  output logic [31:0] rollback_pc_to_cmd,
  output logic        predicted_jump_sign_to_cmd
);

  localparam int BHT_SIZE = 1 << BHT_INDEX_BITS;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DROP} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_enable;
  logic [31:0] r_addr;
  logic        r_finish;
  logic [31:0] r_inst;
  logic [31:0] r_pc_out;
  logic [31:0] r_rollback_pc;
  logic        r_pred;
  logic [1:0]  r_bht [BHT_SIZE];

  logic [31:0]               w_imm_j;
  logic [31:0]               w_imm_b;
  logic [31:0]               w_pc_plus4;
  logic [BHT_INDEX_BITS-1:0] w_lookup_idx;
  logic [BHT_INDEX_BITS-1:0] w_update_idx;
  logic                      w_any_full;
  logic                      w_pred;
  logic [31:0]               w_next_pc;
  logic [31:0]               w_rollback_pc;
  logic                      w_unused;

  assign enable_sign_to_mem         = r_enable;
  assign addr_to_mem                = r_addr;
  assign finish_flag_to_cmd         = r_finish;
  assign inst_to_cmd                = r_inst;
  assign pc_to_cmd                  = r_pc_out;
  assign rollback_pc_to_cmd         = r_rollback_pc;
  assign predicted_jump_sign_to_cmd = r_pred;

  assign w_imm_j = {{12{inst_from_mem[31]}}, inst_from_mem[19:12], inst_from_mem[20],
                    inst_from_mem[30:21], 1'b0};
  assign w_imm_b = {{20{inst_from_mem[31]}}, inst_from_mem[7], inst_from_mem[30:25],
                    inst_from_mem[11:8], 1'b0};
  assign w_pc_plus4   = r_pc + 32'd4;
  assign w_lookup_idx = r_pc[BHT_INDEX_BITS+1:2];
  assign w_update_idx = update_pc_from_rob[BHT_INDEX_BITS+1:2];
  assign w_any_full   = full_sign_from_rob | full_sign_from_rs | full_sign_from_ls;
  // Only the BHT index bits of the resolved-branch PC matter.
  assign w_unused     = ^{update_pc_from_rob[31:BHT_INDEX_BITS+2], update_pc_from_rob[1:0]};

  // Next-PC prediction from the returning instruction; BHT read sees pre-update contents.
  always_comb begin
    w_pred        = 1'b0;
    w_next_pc     = w_pc_plus4;
    w_rollback_pc = w_pc_plus4;
    case (inst_from_mem[6:0])
      OP_JAL: begin
        w_pred        = 1'b1;
        w_next_pc     = r_pc + w_imm_j;
        w_rollback_pc = w_pc_plus4;
      end
      OP_BRANCH: begin
        w_pred = r_bht[w_lookup_idx][1];
        if (r_bht[w_lookup_idx][1]) begin
          w_next_pc     = r_pc + w_imm_b;
          w_rollback_pc = w_pc_plus4;
        end else begin
          w_next_pc     = w_pc_plus4;
          w_rollback_pc = r_pc + w_imm_b;
        end
      end
      default: ;
    endcase
  end

  // BHT training: 2-bit saturating counters, weakly not-taken after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BHT_SIZE; i++) r_bht[i] <= 2'b01;
    end else if (rdy && update_sign_from_rob) begin
      if (jump_taken_from_rob) begin
        if (r_bht[w_update_idx] != 2'b11) r_bht[w_update_idx] <= r_bht[w_update_idx] + 2'b01;
      end else begin
        if (r_bht[w_update_idx] != 2'b00) r_bht[w_update_idx] <= r_bht[w_update_idx] - 2'b01;
      end
    end
  end

  // Fetch FSM with registered memory request and packet outputs; rollback overrides everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_enable      <= 1'b0;
      r_addr        <= 32'h0;
      r_finish      <= 1'b0;
      r_inst        <= 32'h0;
      r_pc_out      <= 32'h0;
      r_rollback_pc <= 32'h0;
      r_pred        <= 1'b0;
    end else if (rdy) begin
      r_finish <= 1'b0;
      if (rollback_sign_from_rob) begin
        r_pc     <= target_pc_from_rob;
        r_enable <= 1'b0;
        case (r_state)
          // An outstanding request still owes a response that must be swallowed.
          S_BUSY:  r_state <= finish_sign_from_mem ? S_IDLE : S_DROP;
          S_DROP:  r_state <= finish_sign_from_mem ? S_IDLE : S_DROP;
          default: r_state <= S_IDLE;
        endcase
      end else begin
        case (r_state)
          S_IDLE: begin
            if (!w_any_full) begin
              r_enable <= 1'b1;
              r_addr   <= r_pc;
              r_state  <= S_BUSY;
            end
          end
          S_BUSY: begin
            if (finish_sign_from_mem) begin
              r_enable      <= 1'b0;
              r_finish      <= 1'b1;
              r_inst        <= inst_from_mem;
              r_pc_out      <= r_pc;
              r_rollback_pc <= w_rollback_pc;
              r_pred        <= w_pred;
              r_pc          <= w_next_pc;
              r_state       <= S_IDLE;
            end
          end
          S_DROP: begin
            if (finish_sign_from_mem) r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
